// File: rtl/ppu_pkg.sv
// Shared constants and buffer-state encoding for the PPU scanline buffer.
package ppu_pkg;
  localparam int PIX_W = 6;
  localparam int AW = 8;
  localparam int LINE_W = 256;
  localparam logic [PIX_W-1:0] UNDERRUN_IDX = 6'h0f;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    SCAN    = 2'd3
  } buf_st_t;
endpackage

// File: rtl/ppu_linebuf_ram.sv
// Two banks of 2**AW x PIX_W, one write and one registered read port; infers block RAM.
module ppu_linebuf_ram #(
  parameter int PIX_W = ppu_pkg::PIX_W,
  parameter int AW    = ppu_pkg::AW
) (
  input  logic             clk,
  input  logic             we,
  input  logic             wbank,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic             rbank,
  input  logic [AW-1:0]    raddr,
  output logic [PIX_W-1:0] rdata
);
  logic [PIX_W-1:0] mem [0:(2**(AW+1))-1];

  always_ff @(posedge clk) begin
    if (we) mem[{wbank, waddr}] <= wdata;
    rdata <= mem[{rbank, raddr}];
  end
endmodule

// File: rtl/ppu_linebuf_ctrl.sv
// Ping-pong scanline buffer between PPU renderer and VGA scanout; read latency 1.
// PPU_LINEBUF_STATS_EN enables the saturating underrun counter (tied to zero otherwise).
module ppu_linebuf_ctrl #(
  parameter int PIX_W = ppu_pkg::PIX_W,
  parameter int LINE_W = ppu_pkg::LINE_W,
  parameter int AW = ppu_pkg::AW,
  parameter logic [PIX_W-1:0] UNDERRUN_IDX = ppu_pkg::UNDERRUN_IDX
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             frame_start_in,
  input  logic             line_start_in,
  input  logic [9:0]       nes_y_in,
  input  logic             wr_valid_in,
  input  logic [PIX_W-1:0] wr_data_in,
  output logic             wr_ready_out,
  input  logic [AW-1:0]    rd_x_in,
  output logic [PIX_W-1:0] rd_data_out,
  output logic             line_valid_out,
  output logic [7:0]       underrun_cnt_out
);
  import ppu_pkg::*;

  buf_st_t st [2];
  buf_st_t st_n [2];
  logic wr_sel, rd_sel, wr_sel_n, rd_sel_n;
  logic [AW-1:0] wr_ptr, wr_ptr_n;
  logic [9:0] last_y, last_y_n;
  logic last_y_vld, last_y_vld_n;
  logic rdy_q, scan_q;
  logic [PIX_W-1:0] ram_q;
  logic wr_fire, last_pix, new_line;

  assign wr_fire  = wr_valid_in && rdy_q;
  assign last_pix = (int'(wr_ptr) == LINE_W - 1);
  // A repeated y is the line doubler re-scanning the same NES line.
  assign new_line = line_start_in && (!last_y_vld || (nes_y_in != last_y));

  always_comb begin
    st_n[0]      = st[0];
    st_n[1]      = st[1];
    wr_sel_n     = wr_sel;
    rd_sel_n     = rd_sel;
    wr_ptr_n     = wr_ptr;
    last_y_n     = last_y;
    last_y_vld_n = last_y_vld;
    if (frame_start_in) begin
      st_n[0]      = EMPTY;
      st_n[1]      = EMPTY;
      wr_sel_n     = 1'b0;
      rd_sel_n     = 1'b1;
      wr_ptr_n     = '0;
      last_y_vld_n = 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr_n = wr_ptr + 1'b1;
        if (last_pix) begin
          st_n[wr_sel] = FULL;
          wr_sel_n     = ~wr_sel;
        end else begin
          st_n[wr_sel] = FILLING;
        end
      end
      // Eligibility is judged on start-of-cycle state only.
      if (new_line) begin
        last_y_n     = nes_y_in;
        last_y_vld_n = 1'b1;
        if (st[rd_sel] == SCAN) st_n[rd_sel] = EMPTY;
        if (st[~rd_sel] == FULL) begin
          rd_sel_n      = ~rd_sel;
          st_n[~rd_sel] = SCAN;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      st[0]      <= EMPTY;
      st[1]      <= EMPTY;
      wr_sel     <= 1'b0;
      rd_sel     <= 1'b1;
      wr_ptr     <= '0;
      last_y     <= '0;
      last_y_vld <= 1'b0;
      rdy_q      <= 1'b0;
      scan_q     <= 1'b0;
    end else begin
      st[0]      <= st_n[0];
      st[1]      <= st_n[1];
      wr_sel     <= wr_sel_n;
      rd_sel     <= rd_sel_n;
      wr_ptr     <= wr_ptr_n;
      last_y     <= last_y_n;
      last_y_vld <= last_y_vld_n;
      rdy_q      <= (st_n[wr_sel_n] == EMPTY) || (st_n[wr_sel_n] == FILLING);
      scan_q     <= (st[rd_sel] == SCAN);
    end
  end

  ppu_linebuf_ram #(.PIX_W(PIX_W), .AW(AW)) u_ram (
    .clk   (clk_in),
    .we    (wr_fire && !frame_start_in),
    .wbank (wr_sel),
    .waddr (wr_ptr),
    .wdata (wr_data_in),
    .rbank (rd_sel),
    .raddr (rd_x_in),
    .rdata (ram_q)
  );

  assign wr_ready_out   = rdy_q;
  assign rd_data_out    = scan_q ? ram_q : UNDERRUN_IDX;
  assign line_valid_out = (st[rd_sel] == SCAN);

`ifdef PPU_LINEBUF_STATS_EN
  logic underrun;
  logic [7:0] urun_cnt;
  assign underrun = new_line && !frame_start_in && (st[~rd_sel] != FULL);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) urun_cnt <= 8'h00;
    else if (frame_start_in) urun_cnt <= 8'h00;
    else if (underrun && (urun_cnt != 8'hff)) urun_cnt <= urun_cnt + 8'h01;
  end
  assign underrun_cnt_out = urun_cnt;
`else
  assign underrun_cnt_out = 8'h00;
`endif
endmodule

// File: tb/tb_ppu_linebuf_ctrl.sv
// Scoreboard bench for ppu_linebuf_ctrl: line fill/swap, doubler, underrun, frame flush, mid-line reset.
module tb_ppu_linebuf_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       line_start = 1'b0;
  logic [9:0] nes_y = '0;
  logic       wr_valid = 1'b0;
  logic [5:0] wr_data = '0;
  logic       wr_ready;
  logic [7:0] rd_x = '0;
  logic [5:0] rd_data;
  logic       line_valid;
  logic [7:0] urun_cnt;

  int total = 0;
  int bad = 0;
  logic [5:0] exp_q [$];

`ifdef PPU_LINEBUF_STATS_EN
  localparam logic [7:0] URUN_AFTER_ONE = 8'd1;
`else
  localparam logic [7:0] URUN_AFTER_ONE = 8'd0;
`endif

  always #5 clk = ~clk;

  ppu_linebuf_ctrl dut (
    .clk_in           (clk),
    .rst_in           (rst_n),
    .frame_start_in   (frame_start),
    .line_start_in    (line_start),
    .nes_y_in         (nes_y),
    .wr_valid_in      (wr_valid),
    .wr_data_in       (wr_data),
    .wr_ready_out     (wr_ready),
    .rd_x_in          (rd_x),
    .rd_data_out      (rd_data),
    .line_valid_out   (line_valid),
    .underrun_cnt_out (urun_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] pix(input int seed, input int x);
    int v;
    v = seed + x;
    return v[5:0];
  endfunction

  task automatic push_pix(input logic [5:0] d);
    int guard;
    guard = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    while (!wr_ready && guard < 1000) begin
      tick();
      guard++;
    end
    if (guard >= 1000) chk("wr_ready_timeout", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic write_pixels(input int seed, input int first, input int n);
    for (int i = first; i < first + n; i++) push_pix(pix(seed, i));
  endtask

  task automatic line_pulse(input logic [9:0] y);
    line_start = 1'b1;
    nes_y      = y;
    tick();
    line_start = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int x, input logic [5:0] exp);
    rd_x = x[7:0];
    exp_q.push_back(exp);
    tick();
    chk(tag, 32'(rd_data), 32'(exp_q.pop_front()));
  endtask

  initial begin
    #2;
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'h0f);
    chk("rst_line_valid", 32'(line_valid), 32'd0);
    chk("rst_urun", 32'(urun_cnt), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 32'(wr_ready), 32'd1);

    // first line into buffer 0, then scan it
    write_pixels(0, 0, 256);
    chk("t1_ready_buf1", 32'(wr_ready), 32'd1);
    line_pulse(10'd0);
    chk("t1_line_valid", 32'(line_valid), 32'd1);
    rd_chk("t1_rd5", 5, 6'h05);
    rd_chk("t1_rd255", 255, pix(0, 255));
    rd_chk("t1_rd0", 0, 6'h00);

    // second line fills buffer 1; producer stalls on the buffer being scanned
    write_pixels(10, 0, 256);
    chk("t2_stall", 32'(wr_ready), 32'd0);
    line_pulse(10'd7);
    chk("t2_ready_release", 32'(wr_ready), 32'd1);
    chk("t2_line_valid", 32'(line_valid), 32'd1);
    rd_chk("t2_rd5", 5, pix(10, 5));
    line_pulse(10'd7);
    rd_chk("t2_dbl_rd5", 5, pix(10, 5));
    rd_chk("t2_dbl_rd200", 200, pix(10, 200));
    write_pixels(20, 0, 256);
    chk("t2_stall2", 32'(wr_ready), 32'd0);
    line_pulse(10'd8);
    rd_chk("t2_y8_rd5", 5, pix(20, 5));
    chk("t2_urun", 32'(urun_cnt), 32'd0);

    // partial line: swap becomes an underrun
    write_pixels(30, 0, 100);
    line_pulse(10'd9);
    chk("t3_line_valid", 32'(line_valid), 32'd0);
    rd_chk("t3_rd_sub", 5, 6'h0f);
    chk("t3_urun", 32'(urun_cnt), 32'(URUN_AFTER_ONE));
    chk("t3_ready", 32'(wr_ready), 32'd1);

    // frame flush on the 256th write with a concurrent line start
    write_pixels(30, 100, 155);
    wr_valid    = 1'b1;
    wr_data     = pix(30, 255);
    frame_start = 1'b1;
    line_start  = 1'b1;
    nes_y       = 10'd10;
    tick();
    wr_valid    = 1'b0;
    frame_start = 1'b0;
    line_start  = 1'b0;
    chk("t4_ready", 32'(wr_ready), 32'd1);
    chk("t4_line_valid", 32'(line_valid), 32'd0);
    chk("t4_urun", 32'(urun_cnt), 32'd0);
    rd_chk("t4_rd_sub", 0, 6'h0f);
    write_pixels(40, 0, 256);
    line_pulse(10'd10);
    chk("t4_line_valid2", 32'(line_valid), 32'd1);
    rd_chk("t4_rd0", 0, pix(40, 0));
    rd_chk("t4_rd5", 5, pix(40, 5));
    rd_chk("t4_rd255", 255, pix(40, 255));

    // fill both buffers without any line start
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    write_pixels(50, 0, 256);
    chk("t5_ready_256", 32'(wr_ready), 32'd1);
    write_pixels(60, 0, 256);
    chk("t5_ready_512", 32'(wr_ready), 32'd0);
    line_pulse(10'd1);
    chk("t5_ready_still0", 32'(wr_ready), 32'd0);
    rd_chk("t5_rd_buf0", 5, pix(50, 5));
    line_pulse(10'd2);
    chk("t5_ready_release", 32'(wr_ready), 32'd1);
    rd_chk("t5_rd_buf1", 5, pix(60, 5));

    // asynchronous reset mid-line
    write_pixels(0, 0, 50);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", 32'(wr_ready), 32'd0);
    chk("t6_rst_line_valid", 32'(line_valid), 32'd0);
    chk("t6_rst_rd_data", 32'(rd_data), 32'h0f);
    chk("t6_rst_urun", 32'(urun_cnt), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    write_pixels(5, 0, 256);
    line_pulse(10'd3);
    rd_chk("t6_rd0", 0, pix(5, 0));
    rd_chk("t6_rd5", 5, pix(5, 5));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
